// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants for the elastic pipeline register and its per-interface payload widths.
package elastic_pipe_reg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Payload widths for the processor stage boundaries, so each instance takes WIDTH from a name.
  localparam int unsigned IF_ID_WIDTH   = 64;
  localparam int unsigned ID_EX_WIDTH   = 148;
  localparam int unsigned EX_MEM_WIDTH  = 106;
  localparam int unsigned MEM_WB_WIDTH  = 71;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/data slot of the elastic pipeline; data only loads when a valid payload arrives.
module elastic_pipe_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake, bubble collapsing and flush.
// Define ELASTIC_PIPE_REG_TRACE_EN to print a simulation line on every transfer in and out.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] prev_v;
  logic [WIDTH-1:0] d      [DEPTH];
  logic [WIDTH-1:0] prev_d [DEPTH];

  // A stage may advance if it is empty or everything downstream of it advances.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      carry  = ~v[k] | carry;
      adv[k] = carry;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign prev_v[k] = in_valid;
      assign prev_d[k] = in_data;
    end else begin : g_body
      assign prev_v[k] = v[k-1];
      assign prev_d[k] = d[k-1];
    end

    elastic_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .adv        (adv[k]),
      .prev_valid (prev_v[k]),
      .prev_data  (prev_d[k]),
      .valid      (v[k]),
      .data       (d[k])
    );
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v[k]);
    end
  end

`ifdef ELASTIC_PIPE_REG_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && in_valid && in_ready) begin
      $display("%0t IN %h occupancy=%0d", $time, in_data, occupancy);
    end
    if (!rst && out_valid && out_ready) begin
      $display("%0t OUT %h occupancy=%0d", $time, out_data, occupancy);
    end
  end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Scoreboard bench: a position-queue model of the pipeline predicts handshakes; a monitor checks output order/data.
module tb_elastic_pipe_reg;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 3;
  localparam int unsigned OW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [OW-1:0] occupancy;

  logic          flush1 = 1'b0;
  logic          in_valid1 = 1'b0;
  logic [W-1:0]  in_data1 = '0;
  logic          in_ready1;
  logic          out_valid1;
  logic [W-1:0]  out_data1;
  logic          out_ready1 = 1'b0;
  logic [0:0]    occupancy1;

  always #5 clk = ~clk;

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready1), .occupancy(occupancy1)
  );

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] exp_q[$];   // payloads accepted and not yet consumed, oldest first
  int           pos_q[$];   // stage index of each in-flight payload, oldest first
  bit           acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every downstream consumption must match the oldest accepted payload.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %0h, expected no output at %0t", out_data, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL out_data: got %0h, expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  // One clock of the model: check handshake outputs mid-cycle, then move payloads at the edge.
  task automatic step();
    bit pop;
    bit exp_rdy;
    int lim;
    @(negedge clk);
    exp_rdy = !flush && (pos_q.size() < D || out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("occupancy", 32'(occupancy), 32'(pos_q.size()));
    chk("out_valid", 32'(out_valid), 32'(pos_q.size() > 0 && pos_q[0] == D - 1));
    pop = pos_q.size() > 0 && pos_q[0] == D - 1 && out_ready;
    acc = in_valid && exp_rdy;
    if (acc) exp_q.push_back(in_data);
    @(posedge clk);
    if (pop) void'(pos_q.pop_front());
    if (flush) begin
      pos_q.delete();
      exp_q.delete();
    end else begin
      // Each payload moves one slot forward unless the slot ahead stays occupied.
      for (int i = 0; i < pos_q.size(); i++) begin
        lim = (i == 0) ? int'(D) - 1 : pos_q[i-1] - 1;
        pos_q[i] = (pos_q[i] + 1 < lim) ? pos_q[i] + 1 : lim;
      end
      if (acc) pos_q.push_back(0);
    end
    #1;
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] id, input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  initial begin
    bit           pend;
    logic [W-1:0] pdata;

    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst1_out_valid", 32'(out_valid1), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst1_in_ready", 32'(in_ready1), 1);
    chk("rst1_out_data", out_data1, 0);
    chk("rst1_occupancy", 32'(occupancy1), 0);

    // Single-stage register: one edge of latency.
    in_valid1 = 1'b1; in_data1 = 32'hDEADBEEF; out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("d1_out_valid", 32'(out_valid1), 1);
    chk("d1_out_data", out_data1, 32'hDEADBEEF);
    chk("d1_occupancy", 32'(occupancy1), 1);
    @(posedge clk); #1;
    chk("d1_drained", 32'(out_valid1), 0);

    // Back-to-back stream with no backpressure.
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

    // Fill against backpressure, then release on the same cycle D enters.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hD, 1'b0, 1'b0);
    chk("full_reject", 32'(acc), 0);
    drive(1'b1, 32'hD, 1'b1, 1'b0);
    chk("full_bypass", 32'(acc), 1);
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse of a lone payload into the output stage.
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    chk("collapse_data", out_data, 32'h11);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Flush a full pipe while upstream offers a payload.
    drive(1'b1, 32'h21, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b1, 32'h23, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset between edges with two payloads in flight.
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    drive(1'b1, 32'h88, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 0);
    chk("async_out_data", out_data, 0);
    chk("async_occupancy", 32'(occupancy), 0);
    pos_q.delete();
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;

    // Random traffic, with upstream holding each payload until accepted.
    pend = 1'b0;
    pdata = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(3) != 0) begin
        pend  = 1'b1;
        pdata = $urandom;
      end
      drive(pend, pend ? pdata : '0, $urandom_range(9) < 7, $urandom_range(31) == 0);
      if (acc) pend = 1'b0;
    end

    for (int c = 0; c < 20 && pos_q.size() != 0; c++) drive(1'b0, '0, 1'b1, 1'b0);
    chk("drain_model", 32'(pos_q.size()), 0);
    chk("drain_scoreboard", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
